// File: rtl/rom_fetch.sv
// Read initiator for a registered single-cycle ROM: walks base_addr..base_addr+length-1 and
// streams each byte over valid/ready. Define ROM_FETCH_TERM_EN to stop early on the TERM byte.
module rom_fetch #(
  parameter int                ADDR_W = 9,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] TERM   = 8'hFF
) (
  input  logic              control,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_cnt,
  output logic              term_hit
);

`ifdef ROM_FETCH_TERM_EN
  localparam bit TERM_EN = 1'b1;
`else
  localparam bit TERM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr, addr_nxt;
  logic [ADDR_W:0]   len_q, cnt_inc;
  logic              term_seen;
  logic              term_q;

  // With the feature disabled term_seen is constant 0, so term_q never sets.
  assign term_seen = TERM_EN && (mem_data == TERM);
  assign cnt_inc   = word_cnt + (ADDR_W+1)'(1);
  assign term_hit  = term_q;

  always_ff @(posedge control or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = cur_addr;
    case (state)
      S_IDLE: if (start) begin
        if (length == '0) state_nxt = S_DONE;
        else begin
          state_nxt = S_ISSUE;
          addr_nxt  = base_addr;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = term_seen ? S_DONE : S_HOLD;
      S_HOLD: if (data_ready) begin
        addr_nxt  = cur_addr + ADDR_W'(1);
        state_nxt = (cnt_inc == len_q) ? S_DONE : S_ISSUE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    data_valid = (state == S_HOLD);
  end

  // ROM port is registered off the next state so mem_rd lines up exactly with ISSUE.
  always_ff @(posedge control or posedge reset) begin
    if (reset) begin
      cur_addr <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      len_q    <= '0;
      word_cnt <= '0;
      data_out <= '0;
      term_q   <= 1'b0;
    end else begin
      cur_addr <= addr_nxt;
      mem_rd   <= (state_nxt == S_ISSUE);
      if (state_nxt == S_ISSUE) mem_addr <= addr_nxt;
      if (state == S_IDLE && start) begin
        len_q    <= length;
        word_cnt <= '0;
        term_q   <= 1'b0;
      end
      if (state == S_WAIT) begin
        if (term_seen) term_q   <= 1'b1;
        else           data_out <= mem_data;
      end
      if (state == S_HOLD && data_ready) word_cnt <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_rom_fetch.sv
// Directed bench for rom_fetch: ROM model, byte scoreboard, done-timing and port checks.
module tb_rom_fetch;
  logic       control = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [8:0] base_addr = '0;
  logic [9:0] length = '0;
  logic [8:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data = '0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b1;
  logic       busy, done;
  logic [9:0] word_cnt;
  logic       term_hit;

  rom_fetch dut (
    .control(control), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .done(done), .word_cnt(word_cnt), .term_hit(term_hit)
  );

  always #5 control = ~control;

  logic [7:0] rom [512];
  always @(posedge control) if (mem_rd) mem_data <= rom[mem_addr];

  int         total = 0, bad = 0, cyc = 0, rd_cnt = 0;
  int         exp_n, rd0;
  bit         exp_term;
  logic [7:0] exp_q [$];
  logic [8:0] addr_log [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  always @(negedge control) begin
    if (mem_rd) begin
      rd_cnt++;
      addr_log.push_back(mem_addr);
    end
    if (data_valid && data_ready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL extra_byte: got %0d want none", data_out);
      end
      if (exp_q.size() != 0) chk("data", data_out, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge control);
    #2;
    cyc++;
  endtask

  task automatic begin_xfer(input int base, input int len);
    logic [7:0] b;
    exp_n    = 0;
    exp_term = 1'b0;
    for (int i = 0; i < len; i++) begin
      b = rom[(base + i) % 512];
`ifdef ROM_FETCH_TERM_EN
      if (b == 8'hFF) begin
        exp_term = 1'b1;
        break;
      end
`endif
      exp_q.push_back(b);
      exp_n++;
    end
    rd0 = rd_cnt;
    addr_log.delete();
    start     = 1'b1;
    base_addr = 9'(base);
    length    = 10'(len);
    cyc       = 0;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input bit chk_cyc);
    int guard = 0;
    while (!done && guard < 3000) begin
      step();
      guard++;
    end
    chk("done_seen", 32'(done), 1);
    if (chk_cyc) chk("done_cycle", cyc, 3 * exp_n + 1 + (exp_term ? 2 : 0));
    chk("word_cnt", 32'(word_cnt), exp_n);
    chk("term_hit", 32'(term_hit), 32'(exp_term));
    chk("rd_count", rd_cnt - rd0, exp_n + (exp_term ? 1 : 0));
    chk("queue_empty", exp_q.size(), 0);
    step();
    chk("done_pulse", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  task automatic wait_byte(input logic [7:0] v);
    int guard = 0;
    while (!(data_valid && data_out == v) && guard < 3000) begin
      step();
      guard++;
    end
    chk("byte_seen", 32'(data_valid && data_out == v), 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_data_valid", 32'(data_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_word_cnt", 32'(word_cnt), 0);
    chk("rst_term_hit", 32'(term_hit), 0);
  endtask

  initial begin
    int r;
    for (int i = 0; i < 512; i++) rom[i] = 8'hFF;
    rom[0] = 8'd27; rom[1] = 8'd5; rom[2] = 8'd33; rom[3] = 8'd3;
    rom[510] = 8'h10; rom[511] = 8'h11;

    step();
    chk_reset_vals();
    reset = 1'b0;
    step();

    // zero-length request: done next cycle, no ROM read
    begin_xfer(0, 0);
    wait_done(1'b1);

    // basic 4-byte block
    begin_xfer(0, 4);
    wait_done(1'b1);

    // runs into erased area
    begin_xfer(0, 10);
    wait_done(1'b1);

    // backpressure on byte 5
    begin_xfer(0, 4);
    wait_byte(8'd5);
    data_ready = 1'b0;
    r = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(data_valid), 1);
      chk("bp_data", 32'(data_out), 5);
    end
    chk("bp_no_rd", rd_cnt, r);
    data_ready = 1'b1;
    wait_done(1'b0);

    // start pulse mid-transfer must be ignored
    begin_xfer(0, 4);
    step();
    step();
    start = 1'b1; base_addr = 9'd100; length = 10'd1;
    step();
    start = 1'b0;
    wait_done(1'b1);

    // address wrap 511 -> 0
    begin_xfer(510, 3);
    wait_done(1'b1);
    chk("wrap_n", addr_log.size(), 3);
    if (addr_log.size() == 3) begin
      chk("wrap_a0", 32'(addr_log[0]), 510);
      chk("wrap_a1", 32'(addr_log[1]), 511);
      chk("wrap_a2", 32'(addr_log[2]), 0);
    end

    // asynchronous reset during HOLD of word 2
    begin_xfer(0, 4);
    wait_byte(8'd5);
    data_ready = 1'b0;
    exp_q.delete();
    #1 reset = 1'b1;
    #1 chk_reset_vals();
    step();
    reset = 1'b0;
    data_ready = 1'b1;
    step();
    begin_xfer(1, 1);
    wait_done(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
